// File: rtl/vga_scan_gen_if.sv
// Scan-output bundle of the raster timing generator: syncs, visible flag,
// scan position and the two sprite ROM addresses.
// master = timing generator (drives everything), slave = pixel mux / consumers.
interface vga_scan_gen_if;
    logic        hsync;          // active-low horizontal sync
    logic        vsync;          // active-low vertical sync
    logic        valid;          // scan position inside the visible area
    logic [9:0]  h_cnt;          // current column
    logic [9:0]  v_cnt;          // current line
    logic [16:0] pixel_addr;     // drive-mode icon ROM address
    logic [16:0] pixel_addr_num; // digit tile ROM address
    logic        vblank_start;   // one-cycle pulse at the first blanked line

    modport master (
        output hsync, vsync, valid, h_cnt, v_cnt,
               pixel_addr, pixel_addr_num, vblank_start
    );

    modport slave (
        input  hsync, vsync, valid, h_cnt, v_cnt,
               pixel_addr, pixel_addr_num, vblank_start
    );
endinterface

// File: rtl/vga_scan_gen.sv
// Purpose : 640x480@60 raster timing source with icon/digit sprite ROM addressing.
// Latency : every output is registered and describes the h_cnt/v_cnt of the same cycle.
// Backpressure: none; free-running at one pixel per clk_25MHz cycle.
// Ports   : clk_25MHz (pixel clock), rst_n (async active-low reset),
//           scan (master modport: hsync, vsync, valid, h_cnt, v_cnt,
//           pixel_addr, pixel_addr_num, vblank_start).
module vga_scan_gen #(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int DIG_X0 = 224,   // left column of the three digit tiles
    parameter int DIG_Y0 = 208    // top line of the digit tiles
) (
    input  logic           clk_25MHz,
    input  logic           rst_n,
    vga_scan_gen_if.master scan
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISP);
    localparam logic [9:0] V_VIS  = 10'(V_DISP);
    localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC);
    localparam logic [9:0] TILE   = 10'd64;
    localparam logic [9:0] DX_BEG = 10'(DIG_X0);
    localparam logic [9:0] DX_END = 10'(DIG_X0 + 3 * 64 - 1);
    localparam logic [9:0] DY_BEG = 10'(DIG_Y0);
    localparam logic [9:0] DY_END = 10'(DIG_Y0 + 64 - 1);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        valid_q, valid_d;
    logic [16:0] addr_q, addr_d;
    logic [16:0] num_q, num_d;
    logic        vblank_q, vblank_d;
    logic [9:0]  dx, dy;

    // All decoded outputs are derived from the next-state counters so that
    // after the register stage they line up with the counters they describe.
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end

        hsync_d  = !((h_d >= HS_BEG) && (h_d < HS_END));
        vsync_d  = !((v_d >= VS_BEG) && (v_d < VS_END));
        valid_d  = (h_d < H_VIS) && (v_d < V_VIS);
        vblank_d = (h_d == '0) && (v_d == V_VIS);

        // Icon: row*64 + col is just the two 6-bit fields concatenated.
        addr_d = '0;
        if ((h_d < TILE) && (v_d < TILE)) begin
            addr_d = 17'({v_d, 6'b0}) | 17'(h_d);
        end

        // Digits: the column offset is masked to 6 bits so each of the three
        // tiles restarts at column 0 and reads the same 64x64 glyph window.
        dx    = h_d - DX_BEG;
        dy    = v_d - DY_BEG;
        num_d = '0;
        if ((h_d >= DX_BEG) && (h_d <= DX_END) && (v_d >= DY_BEG) && (v_d <= DY_END)) begin
            num_d = 17'({dy, 6'b0}) | 17'(dx & 10'h03F);
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            num_q    <= '0;
            vblank_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            num_q    <= num_d;
            vblank_q <= vblank_d;
        end
    end

    assign scan.h_cnt          = h_q;
    assign scan.v_cnt          = v_q;
    assign scan.hsync          = hsync_q;
    assign scan.vsync          = vsync_q;
    assign scan.valid          = valid_q;
    assign scan.pixel_addr     = addr_q;
    assign scan.pixel_addr_num = num_q;
    assign scan.vblank_start   = vblank_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen. Horizontal timing is the real 800-clock line; the
// vertical timing and the digit row origin are shrunk so a whole frame plus
// the mid-frame reset scenario stay short. All expectations derive from the
// bench's own constants.
module tb_vga_scan_gen;

    localparam int H_DISP = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_DISP = 8;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 56;
    localparam int DIG_X0 = 224;
    localparam int DIG_Y0 = 4;
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    vga_scan_gen_if scan_if ();

    vga_scan_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .DIG_X0(DIG_X0), .DIG_Y0(DIG_Y0)
    ) dut (
        .clk_25MHz (clk),
        .rst_n     (rst_n),
        .scan      (scan_if)
    );

    typedef struct {
        int h;
        int v;
        int addr;
        int num;
        bit icon;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;

    // Frame statistics gathered by the monitor over the first FRAME samples
    // after reset release: positions (1,0) .. (0,0) of the next frame.
    bit mon_en  = 1'b0;
    int samp_n  = 0;
    int valid_n = 0;
    int vs_n    = 0;
    int vs_h    = -1;
    int vs_v    = -1;
    int vb_n    = 0;
    int vb_h    = -1;
    int vb_v    = -1;
    int vwrap_n = 0;
    int prev_v  = 0;
    int mon_h;
    int mon_v;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int h, input int v, input int addr, input int num, input bit icon);
        exp_t e;
        e.h = h; e.v = v; e.addr = addr; e.num = num; e.icon = icon;
        sb.push_back(e);
    endtask

    // Monitor: accumulates frame statistics and retires scoreboard entries
    // when the scan reaches their position.
    initial forever begin
        @(negedge clk);
        if (mon_en && samp_n < FRAME) begin
            mon_h = int'(scan_if.h_cnt);
            mon_v = int'(scan_if.v_cnt);
            samp_n++;
            if (scan_if.valid) valid_n++;
            if (!scan_if.vsync) begin
                if (vs_n == 0) begin vs_h = mon_h; vs_v = mon_v; end
                vs_n++;
            end
            if (scan_if.vblank_start) begin
                vb_n++; vb_h = mon_h; vb_v = mon_v;
            end
            if (mon_h == 0 && mon_v == 0 && prev_v == V_TOTAL - 1) vwrap_n++;
            prev_v = mon_v;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].h == mon_h && sb[i].v == mon_v) begin
                    tests_run++;
                    if (int'(scan_if.pixel_addr) !== sb[i].addr ||
                        int'(scan_if.pixel_addr_num) !== sb[i].num) begin
                        fails++;
                        $display("FAIL %s at (%0d,%0d): pixel_addr=%0d pixel_addr_num=%0d, expected %0d/%0d",
                                 sb[i].icon ? "icon_addr" : "digit_addr", mon_h, mon_v,
                                 scan_if.pixel_addr, scan_if.pixel_addr_num, sb[i].addr, sb[i].num);
                    end
                    sb.delete(i);
                    break;
                end
            end
        end
    end

    task automatic test_icon_addr();
        push(64, 0, 0, 0, 1'b1);
        push(5, 3, 197, 0, 1'b1);
        push(10, 2, 138, 0, 1'b1);
        push(63, 63, 4095, 0, 1'b1);
    endtask

    task automatic test_digit_addr();
        push(DIG_X0 - 1,   DIG_Y0,      0, 0,    1'b0);
        push(DIG_X0,       DIG_Y0,      0, 0,    1'b0);
        push(DIG_X0 + 63,  DIG_Y0,      0, 63,   1'b0);
        push(DIG_X0 + 64,  DIG_Y0 + 1,  0, 64,   1'b0);
        push(DIG_X0 + 128, DIG_Y0 + 2,  0, 128,  1'b0);
        push(DIG_X0 + 191, DIG_Y0 + 63, 0, 4095, 1'b0);
        push(DIG_X0 + 192, DIG_Y0 + 63, 0, 0,    1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        tests_run++;
        if (scan_if.h_cnt !== 10'd0 || scan_if.v_cnt !== 10'd0) begin
            fails++;
            $display("FAIL reset_cnt: h_cnt=%0d v_cnt=%0d, expected 0/0", scan_if.h_cnt, scan_if.v_cnt);
        end
        tests_run++;
        if (scan_if.hsync !== 1'b1 || scan_if.vsync !== 1'b1) begin
            fails++;
            $display("FAIL reset_sync: hsync=%b vsync=%b, expected 1/1", scan_if.hsync, scan_if.vsync);
        end
        tests_run++;
        if (scan_if.valid !== 1'b0 || scan_if.vblank_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: valid=%b vblank_start=%b, expected 0/0", scan_if.valid, scan_if.vblank_start);
        end
        tests_run++;
        if (scan_if.pixel_addr !== 17'd0 || scan_if.pixel_addr_num !== 17'd0) begin
            fails++;
            $display("FAIL reset_addr: pixel_addr=%0d pixel_addr_num=%0d, expected 0/0",
                     scan_if.pixel_addr, scan_if.pixel_addr_num);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        tests_run++;
        if (scan_if.h_cnt !== 10'd1 || scan_if.v_cnt !== 10'd0 || scan_if.valid !== 1'b1) begin
            fails++;
            $display("FAIL release_first: h_cnt=%0d v_cnt=%0d valid=%b, expected 1/0/1",
                     scan_if.h_cnt, scan_if.v_cnt, scan_if.valid);
        end
    endtask

    // Expects to be entered at position (1,0); walks 800 samples to (0,1).
    task automatic test_line(input string tag);
        int hs_n = 0;
        int hs_first = -1;
        int vs_low = 0;
        int prev_h = -1;
        int prev_vv = -1;
        bit wrap_ok = 1'b0;
        int ch;
        int cv;
        for (int i = 0; i < H_TOTAL; i++) begin
            ch = int'(scan_if.h_cnt);
            cv = int'(scan_if.v_cnt);
            if (!scan_if.hsync) begin
                if (hs_n == 0) hs_first = ch;
                hs_n++;
            end
            if (!scan_if.vsync) vs_low++;
            if (prev_h == H_TOTAL - 1) wrap_ok = (ch == 0 && prev_vv == 0 && cv == 1);
            prev_h  = ch;
            prev_vv = cv;
            step();
        end
        tests_run++;
        if (hs_n !== H_SYNC) begin
            fails++;
            $display("FAIL %s hsync_width: low for %0d cycles, expected %0d", tag, hs_n, H_SYNC);
        end
        tests_run++;
        if (hs_first !== H_DISP + H_FP) begin
            fails++;
            $display("FAIL %s hsync_start: first low at h=%0d, expected %0d", tag, hs_first, H_DISP + H_FP);
        end
        tests_run++;
        if (wrap_ok !== 1'b1) begin
            fails++;
            $display("FAIL %s h_wrap: wrap 799->0 with v 0->1 seen=%b, expected 1", tag, wrap_ok);
        end
        tests_run++;
        if (vs_low !== 0) begin
            fails++;
            $display("FAIL %s vsync_idle: vsync low %0d cycles on lines 0-1, expected 0", tag, vs_low);
        end
    endtask

    task automatic test_frame();
        int guard = 0;
        while (samp_n < FRAME && guard < FRAME + 1000) begin
            step();
            guard++;
        end
        tests_run++;
        if (samp_n !== FRAME) begin
            fails++;
            $display("FAIL frame_timeout: %0d samples, expected %0d", samp_n, FRAME);
        end
        tests_run++;
        if (valid_n !== H_DISP * V_DISP) begin
            fails++;
            $display("FAIL valid_count: %0d cycles, expected %0d", valid_n, H_DISP * V_DISP);
        end
        tests_run++;
        if (vs_n !== V_SYNC * H_TOTAL) begin
            fails++;
            $display("FAIL vsync_width: %0d cycles, expected %0d", vs_n, V_SYNC * H_TOTAL);
        end
        tests_run++;
        if (vs_h !== 0 || vs_v !== V_DISP + V_FP) begin
            fails++;
            $display("FAIL vsync_start: (%0d,%0d), expected (0,%0d)", vs_h, vs_v, V_DISP + V_FP);
        end
        tests_run++;
        if (vb_n !== 1 || vb_h !== 0 || vb_v !== V_DISP) begin
            fails++;
            $display("FAIL vblank_pulse: %0d pulses last at (%0d,%0d), expected 1 at (0,%0d)",
                     vb_n, vb_h, vb_v, V_DISP);
        end
        tests_run++;
        if (vwrap_n !== 1) begin
            fails++;
            $display("FAIL v_wrap: %0d wraps %0d->0, expected 1", vwrap_n, V_TOTAL - 1);
        end
        tests_run++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d address points never reached, expected 0", sb.size());
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (!(int'(scan_if.h_cnt) == 700 && int'(scan_if.v_cnt) == V_DISP + V_FP + 1) && guard < FRAME) begin
            step();
            guard++;
        end
        tests_run++;
        if (scan_if.hsync !== 1'b0 || scan_if.vsync !== 1'b0 || int'(scan_if.h_cnt) != 700) begin
            fails++;
            $display("FAIL mid_pre: h_cnt=%0d hsync=%b vsync=%b, expected 700/0/0",
                     scan_if.h_cnt, scan_if.hsync, scan_if.vsync);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (scan_if.h_cnt !== 10'd0 || scan_if.v_cnt !== 10'd0) begin
            fails++;
            $display("FAIL mid_async_cnt: h_cnt=%0d v_cnt=%0d, expected 0/0", scan_if.h_cnt, scan_if.v_cnt);
        end
        tests_run++;
        if (scan_if.hsync !== 1'b1 || scan_if.vsync !== 1'b1) begin
            fails++;
            $display("FAIL mid_async_sync: hsync=%b vsync=%b, expected 1/1", scan_if.hsync, scan_if.vsync);
        end
        tests_run++;
        if (scan_if.valid !== 1'b0 || scan_if.vblank_start !== 1'b0 ||
            scan_if.pixel_addr !== 17'd0 || scan_if.pixel_addr_num !== 17'd0) begin
            fails++;
            $display("FAIL mid_async_outs: valid=%b vblank=%b addr=%0d num=%0d, expected all 0",
                     scan_if.valid, scan_if.vblank_start, scan_if.pixel_addr, scan_if.pixel_addr_num);
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (scan_if.h_cnt !== 10'd1 || scan_if.v_cnt !== 10'd0 ||
            scan_if.hsync !== 1'b1 || scan_if.vsync !== 1'b1) begin
            fails++;
            $display("FAIL mid_restart: h_cnt=%0d v_cnt=%0d hsync=%b vsync=%b, expected 1/0/1/1",
                     scan_if.h_cnt, scan_if.v_cnt, scan_if.hsync, scan_if.vsync);
        end
    endtask

    initial begin
        test_icon_addr();
        test_digit_addr();
        test_reset();
        test_line("first_line");
        test_frame();
        test_mid_reset();
        test_line("resume_line");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster timing source for the 640x480@60 Hz display path. Runs from the 25 MHz pixel clock.
- Produces hsync, vsync, a display-valid flag, and the h_cnt/v_cnt scan position.
- Also produces the two sprite ROM addresses consumed by the pixel mux:
  - pixel_addr for the 64x64 drive-mode icon at the top-left corner.
  - pixel_addr_num for the three 64x64 digit tiles in the screen centre.
- Emits a one-cycle vertical-blank pulse so upstream logic can update digit/drive values without tearing.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch

Ports:
- clk_25MHz  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- valid  output  1  high while the scan position is in the visible area
- h_cnt  output  10  current column, 0..H_TOTAL-1
- v_cnt  output  10  current line, 0..V_TOTAL-1
- pixel_addr  output  17  icon ROM address
- pixel_addr_num  output  17  digit ROM address
- vblank_start  output  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Reset and interface: one clock, clk_25MHz. Reset rst_n is asynchronous and active-low.
- Derived constants: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
- Reset values while rst_n=0: h_cnt=0, v_cnt=0, hsync=1, vsync=1, valid=0, pixel_addr=0, pixel_addr_num=0, vblank_start=0.
- After reset release:
  - The first rising edge gives h_cnt=1, v_cnt=0.
  - Pixel (0,0) of the first frame is never flagged valid; this is accepted.
- Horizontal counter: h_cnt increments every cycle. At h_cnt=H_TOTAL-1 it wraps to 0 and v_cnt advances.
- Vertical counter: v_cnt wraps from V_TOTAL-1 to 0 in the same cycle that h_cnt wraps. v_cnt changes only on an h_cnt wrap.
- All outputs are registered and mutually consistent: in any cycle, hsync, vsync, valid, the addresses and vblank_start describe the h_cnt/v_cnt shown in that same cycle. Compute them from next-state counter values; no extra pipeline stage.
- hsync = 0 iff H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC (656..751).
- vsync = 0 iff V_DISP+V_FP <= v_cnt < V_DISP+V_FP+V_SYNC (490..491).
- valid = 1 iff h_cnt < H_DISP and v_cnt < V_DISP.
- Icon region, h_cnt<64 and v_cnt<64:
  - pixel_addr = v_cnt*64 + h_cnt (0..4095).
  - pixel_addr = 0 outside the region.
- Digit region, 208<=v_cnt<=271 and 224<=h_cnt<=415:
  - pixel_addr_num = (v_cnt-208)*64 + ((h_cnt-224) mod 64).
  - Consecutive tiles restart at column 0: h_cnt=288 and h_cnt=352 give a column offset of 0.
  - pixel_addr_num = 0 outside the region.
- Address arithmetic uses shifts and masks only; no multiplier. Products are zero-extended to 17 bits.
- ROM read latency of 1 cycle is absorbed downstream. This block does not compensate for it.
- vblank_start = 1 for exactly one cycle, when h_cnt=0 and v_cnt=V_DISP (480). Once per frame.
- Reset asserted mid-frame: all outputs return to reset values immediately, without waiting for a clock. The scan restarts from (0,0) after release; no partial sync pulse is stretched.

Test Plan:
- Reset then release:
  - h_cnt=0, v_cnt=0, hsync=1, vsync=1, valid=0 during reset.
  - 1 cycle after release, h_cnt=1, valid=1.
- Run one line, 800 cycles:
  - hsync low for exactly 96 cycles, starting at h_cnt=656.
  - h_cnt wraps 799->0 while v_cnt goes 0->1.
- Run one full frame, 420000 cycles:
  - vsync low for exactly 1600 cycles, starting at v_cnt=490, h_cnt=0.
  - v_cnt wraps 524->0.
  - vblank_start pulses once, at (0,480).
  - valid is high for exactly 307200 cycles.
- Icon addresses:
  - At (h=5, v=3), pixel_addr=197.
  - At (63,63), pixel_addr=4095.
  - At (64,0), pixel_addr=0.
- Digit addresses:
  - At (224,208), pixel_addr_num=0.
  - At (287,208), pixel_addr_num=63.
  - At (288,209), pixel_addr_num=64.
  - At (415,271), pixel_addr_num=4095.
  - At (416,271), pixel_addr_num=0.
- Assert rst_n at (h=700, v=491), mid-hsync and mid-vsync:
  - hsync and vsync go to 1 and counters go to 0 asynchronously, before the next clock edge.
  - Normal timing resumes after release.
